// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, ALU op encodings, the packed
// control-strobe struct and the opcode-to-controls decode function.
package cpu_pkg;

  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_NOP = 3'b000;
  localparam logic [OPW-1:0] OP_ADD = 3'b100;
  localparam logic [OPW-1:0] OP_SUB = 3'b101;
  localparam logic [OPW-1:0] OP_LW  = 3'b110;
  localparam logic [OPW-1:0] OP_SW  = 3'b111;

  localparam logic ALUOP_ADD = 1'b0;
  localparam logic ALUOP_SUB = 1'b1;

  // Field order sets the packed bit order: registerwrite is the MSB.
  typedef struct packed {
    logic registerwrite;
    logic aluop;
    logic alusrc;
    logic memw;
    logic mem2reg;
  } ctrl_t;

  // Pure decode. Reserved opcodes and opcodes with unknown bits fall to the
  // default branch and produce all-zero (NOP) controls.
  function automatic ctrl_t decode_op(input logic [OPW-1:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_ADD: begin
        c.registerwrite = 1'b1;
        c.aluop         = ALUOP_ADD;
      end
      OP_SUB: begin
        c.registerwrite = 1'b1;
        c.aluop         = ALUOP_SUB;
      end
      OP_LW: begin
        c.registerwrite = 1'b1;
        c.aluop         = ALUOP_ADD;
        c.alusrc        = 1'b1;
        c.mem2reg       = 1'b1;
      end
      OP_SW: begin
        c.aluop  = ALUOP_ADD;
        c.alusrc = 1'b1;
        c.memw   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instruction_decode.sv
// Main control decoder: registers the decoded control strobes of inst.
// Ports:
//   sysclk        - system clock, rising edge
//   reset         - synchronous active-high reset, clears all outputs
//   inst          - 3-bit opcode
//   registerwrite - register-file write enable
//   aluop         - ALU op (0 add, 1 subtract)
//   alusrc        - ALU B source (0 rs2, 1 immediate)
//   memw          - data-memory write enable
//   mem2reg       - writeback select (0 ALU, 1 memory)
module instruction_decode
  import cpu_pkg::*;
(
  input  logic           sysclk,
  input  logic           reset,
  input  logic [OPW-1:0] inst,
  output logic           registerwrite,
  output logic           aluop,
  output logic           alusrc,
  output logic           memw,
  output logic           mem2reg
);

  ctrl_t ctrl_q;

  // Single register stage; reset wins over decode.
  always_ff @(posedge sysclk) begin
    if (reset) ctrl_q <= '0;
    else       ctrl_q <= decode_op(inst);
  end

  assign registerwrite = ctrl_q.registerwrite;
  assign aluop         = ctrl_q.aluop;
  assign alusrc        = ctrl_q.alusrc;
  assign memw          = ctrl_q.memw;
  assign mem2reg       = ctrl_q.mem2reg;

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed vector table,
// hand-written hold sequence, and a random run including X opcodes.
module tb_instruction_decode;
  import cpu_pkg::*;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [2:0] inst;
  logic       registerwrite, aluop, alusrc, memw, mem2reg;

  int checks = 0;
  int errors = 0;

  instruction_decode dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .inst         (inst),
    .registerwrite(registerwrite),
    .aluop        (aluop),
    .alusrc       (alusrc),
    .memw         (memw),
    .mem2reg      (mem2reg)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic       rst;
    logic [2:0] op;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [4:0] outs();
    return {registerwrite, aluop, alusrc, memw, mem2reg};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act);
    checks++;
    if (act !== 1'b0) begin
      errors++;
      $display("FAIL %s: got %b expected 0", name, act);
    end
  endtask

  // Drive inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic rst, input logic [2:0] op);
    reset = rst;
    inst  = op;
    @(posedge sysclk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    inst  = 3'b110;

    vecs.push_back('{1'b1, 3'b110, 5'b00000, "reset_edge1"});
    vecs.push_back('{1'b1, 3'b110, 5'b00000, "reset_edge2"});
    vecs.push_back('{1'b0, 3'b110, 5'b10101, "release_lw"});
    vecs.push_back('{1'b0, 3'b100, 5'b10000, "sweep_add"});
    vecs.push_back('{1'b0, 3'b101, 5'b11000, "sweep_sub"});
    vecs.push_back('{1'b0, 3'b110, 5'b10101, "sweep_lw"});
    vecs.push_back('{1'b0, 3'b111, 5'b00110, "sweep_sw"});
    vecs.push_back('{1'b0, 3'b000, 5'b00000, "nop_000"});
    vecs.push_back('{1'b0, 3'b001, 5'b00000, "nop_001"});
    vecs.push_back('{1'b0, 3'b010, 5'b00000, "nop_010"});
    vecs.push_back('{1'b0, 3'b011, 5'b00000, "nop_011"});
    vecs.push_back('{1'b0, 3'b100, 5'b10000, "after_nop_add"});
    vecs.push_back('{1'b0, 3'b111, 5'b00110, "steady_sw"});
    vecs.push_back('{1'b1, 3'b111, 5'b00000, "midstream_reset"});
    vecs.push_back('{1'b0, 3'b111, 5'b00110, "reset_release_sw"});
    vecs.push_back('{1'b0, 3'b111, 5'b00110, "repeat_sw"});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].op);
      chk(vecs[i].name, outs(), vecs[i].exp);
    end

    // Latency/hold: inst changes between edges, outputs wait for the edge.
    step(1'b0, 3'b100);
    chk("hold_load_add", outs(), 5'b10000);
    inst = 3'b111;
    #3;
    chk("hold_mid_cycle", outs(), 5'b10000);
    #4;
    chk("hold_before_edge", outs(), 5'b10000);
    @(posedge sysclk);
    #1;
    chk("hold_after_edge", outs(), 5'b00110);

    // Random run with occasional unknown opcode bits.
    for (int n = 0; n < 200; n++) begin
      logic [2:0] v;
      logic [4:0] exp;
      v = 3'($urandom);
      if ($urandom_range(0, 3) == 0) v[$urandom_range(0, 2)] = 1'bx;
      exp = $isunknown(v) ? 5'b00000 : decode_op(v);
      step(1'b0, v);
      chk("random_decode", outs(), exp);
      chk_bit("inv_memw_and_regwrite", memw & registerwrite);
      chk_bit("inv_mem2reg_no_regwrite", mem2reg & ~registerwrite);
      chk_bit("inv_memw_no_alusrc", memw & ~alusrc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Main control decoder for the single-cycle-issue datapath.
- Takes the 3-bit instruction opcode and produces the five datapath control strobes: register-file write enable, ALU operation select, ALU B-operand source select, data-memory write enable, and writeback mux select.
- Outputs are registered on sysclk and feed the execute, memory and writeback control points.

Parameters:
- OPW, 3, opcode width in bits; fixed at 3, listed for package consistency only.

Ports:
- sysclk  input  1  system clock, all state updates on the rising edge
- reset  input  1  synchronous reset, active-high
- inst  input  3  instruction opcode
- registerwrite  output  1  register-file write enable
- aluop  output  1  ALU operation: 0 = add, 1 = subtract
- alusrc  output  1  ALU B-operand select: 0 = register rs2, 1 = sign-extended immediate
- memw  output  1  data-memory write enable
- mem2reg  output  1  writeback select: 0 = ALU result, 1 = memory read data

Behaviour:
- Interface: one clock (sysclk); reset is synchronous and active-high. All five outputs are flops clocked by the rising edge of sysclk.
- Reset: when reset=1 at a rising edge, all outputs become 0 on that edge. Reset has priority over the decode.
- Reset asserted mid-stream clears the outputs on the next edge regardless of inst. The first edge with reset=0 loads the decode of the inst value present at that edge.
- Latency: exactly 1 cycle. The inst value sampled at rising edge N appears on the outputs after edge N and holds until edge N+1. There is no combinational path from inst to any output.
- Decode table (registerwrite, aluop, alusrc, memw, mem2reg):
  - 100 ADD (rd = rs1 + rs2): 1,0,0,0,0
  - 101 SUB (rd = rs1 - rs2): 1,1,0,0,0
  - 110 LW (rd = mem[rs1 + imm]): 1,0,1,0,1
  - 111 SW (mem[rs1 + imm] = rs2): 0,0,1,1,0
  - 0xx (000, 001, 010, 011) NOP/reserved: 0,0,0,0,0
- Invariants that must hold on every cycle:
  - memw and registerwrite are never both 1.
  - mem2reg=1 implies registerwrite=1.
  - memw=1 implies alusrc=1.
- X/Z on inst: treat as NOP (all outputs 0) when inst contains unknown bits in simulation. Synthesis uses a default branch giving all zeros.
- No handshake and no internal state beyond the five output flops. An unchanged inst reproduces identical outputs every cycle.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants OP_ADD=3'b100, OP_SUB=3'b101, OP_LW=3'b110, OP_SW=3'b111, OP_NOP=3'b000.
  - ALUOP_ADD=1'b0, ALUOP_SUB=1'b1.
  - packed control struct {registerwrite, aluop, alusrc, memw, mem2reg}.
  - pure function decode_op(opcode) returning that struct.
- No sub-module. The block is the decode function plus one register stage of the control struct.
- The same decode_op is reused by the bench as its reference model.

Test Plan:
- Reset: reset=1 for 2 edges with inst=3'b110 -> all outputs 0. Release reset with inst=110 -> next edge gives 1,0,1,0,1.
- Sweep: drive inst 100,101,110,111 on consecutive edges -> outputs one cycle later are 10000, 11000, 10101, 00110 in that order.
- NOP/reserved: inst 000, 001, 010, 011 each for one cycle -> all outputs 0. Then inst=100 -> 10000 next cycle.
- Latency and hold: change inst between edges from 100 to 111 -> outputs stay 10000 until the following rising edge, then 00110. No glitch mid-cycle.
- Mid-stream reset: inst=111 steady, assert reset for 1 edge -> outputs 0 for that cycle. Deassert -> 00110 on the next edge.
- Invariant check: random inst including X bits for 200 cycles, compared against decode_op delayed 1 cycle. memw&registerwrite never 1; X inputs produce all zeros.
